joystick_step_ctrl: RTL and testbench

Consumes the debounced joystick levels and the active-low fire pulse, and converts them into discrete game commands. Held directions produce one step immediately, then auto-repeat after an initial delay. Fire is rate-limited by a cooldown. Commands go to the game-logic stage over two independent valid/ready channels.

---
 rtl/joystick_step_ctrl.sv | 116 +++++++++++
 tb/tb_joystick_step_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_step_ctrl.sv
// Joystick-to-command converter: direction steps with delayed auto-repeat and a
// rate-limited fire, each delivered over its own single-entry valid/ready channel.
module joystick_step_ctrl #(
    parameter int unsigned DELAY_CYC    = 12_500_000,
    parameter int unsigned REPEAT_CYC   = 5_000_000,
    parameter int unsigned COOLDOWN_CYC = 10_000_000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire_n,
    output logic       o_move_valid,
    output logic [1:0] o_move_dir,
    input  logic       i_move_ready,
    output logic       o_fire_valid,
    input  logic       i_fire_ready,
    output logic       o_dir_held
);

    typedef enum logic [1:0] {StIdle, StFirst, StRepeat} state_e;

    localparam logic [2:0] ResNone = 3'b000;

    state_e           state_q;
    logic [2:0]       res_d, res_q;  // {active, dir}
    logic [2:0]       dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cool_q;
    logic             fire_req_q;
    logic             change, step, fire_take;

    always_comb begin
        res_d = ResNone;
        if (i_up && !i_down) begin
            res_d = 3'b100;
        end else if (i_down && !i_up) begin
            res_d = 3'b101;
        end else if (i_left && !i_right) begin
            res_d = 3'b110;
        end else if (i_right && !i_left) begin
            res_d = 3'b111;
        end
    end

    always_comb begin
        change    = (res_q != dir_q);
        step      = res_q[2] && (change || (state_q != StIdle && cnt_q == '0));
        fire_take = !i_fire_n && (cool_q == '0);
    end

    // Move FSM; the counter keeps running regardless of consumer backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            res_q        <= ResNone;
            dir_q        <= ResNone;
            cnt_q        <= '0;
            o_move_valid <= 1'b0;
            o_move_dir   <= 2'd0;
            o_dir_held   <= 1'b0;
        end else begin
            res_q <= res_d;
            dir_q <= res_q;
            if (!res_q[2]) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                o_dir_held <= 1'b0;
            end else if (change) begin
                state_q    <= StFirst;
                cnt_q      <= CNT_W'(DELAY_CYC - 1);
                o_dir_held <= 1'b1;
            end else if (state_q != StIdle) begin
                if (cnt_q == '0) begin
                    state_q <= StRepeat;
                    cnt_q   <= CNT_W'(REPEAT_CYC - 1);
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end

            // A newer step overwrites an unconsumed one.
            if (step) begin
                o_move_valid <= 1'b1;
                o_move_dir   <= res_q[1:0];
            end else if (o_move_valid && i_move_ready) begin
                o_move_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_req_q   <= 1'b0;
            cool_q       <= '0;
            o_fire_valid <= 1'b0;
        end else begin
            fire_req_q <= fire_take;
            if (fire_take) begin
                cool_q <= CNT_W'(COOLDOWN_CYC - 1);
            end else if (cool_q != '0) begin
                cool_q <= cool_q - CNT_W'(1);
            end

            if (fire_req_q) begin
                o_fire_valid <= 1'b1;
            end else if (o_fire_valid && i_fire_ready) begin
                o_fire_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joystick_step_ctrl.sv
// Directed bench for joystick_step_ctrl with short delays (4/2/3 cycles).
module tb_joystick_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic       i_fire_n = 1'b1;
    logic       i_move_ready = 1'b1;
    logic       i_fire_ready = 1'b1;
    logic       o_move_valid;
    logic [1:0] o_move_dir;
    logic       o_fire_valid;
    logic       o_dir_held;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    joystick_step_ctrl #(
        .DELAY_CYC   (4),
        .REPEAT_CYC  (2),
        .COOLDOWN_CYC(3),
        .CNT_W       (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_up        (i_up),
        .i_down      (i_down),
        .i_left      (i_left),
        .i_right     (i_right),
        .i_fire_n    (i_fire_n),
        .o_move_valid(o_move_valid),
        .o_move_dir  (o_move_dir),
        .i_move_ready(i_move_ready),
        .o_fire_valid(o_fire_valid),
        .i_fire_ready(i_fire_ready),
        .o_dir_held  (o_dir_held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves rst_n released just after an edge; the next edge is cycle 1.
    task automatic do_reset();
        i_up = 0; i_down = 0; i_left = 0; i_right = 0;
        i_fire_n = 1; i_move_ready = 1; i_fire_ready = 1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        i_right = 1;
        #1;
        vectors++;
        if ({o_move_valid, o_move_dir, o_fire_valid, o_dir_held} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {o_move_valid, o_move_dir, o_fire_valid, o_dir_held});
        end
        do_reset();
        repeat (3) begin
            tick();
            vectors++;
            if ({o_move_valid, o_fire_valid, o_dir_held} !== 3'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset cyc %0d: got %b expected 000", cyc,
                         {o_move_valid, o_fire_valid, o_dir_held});
            end
        end
    endtask

    task automatic test_hold_right();
        logic exp_v, exp_h;
        do_reset();
        while (cyc < 9) tick();
        i_right = 1;
        repeat (12) begin
            tick();
            exp_v = (cyc == 11 || cyc == 15 || cyc == 17 || cyc == 19);
            exp_h = (cyc >= 11 && cyc <= 20);
            vectors++;
            if (o_move_valid !== exp_v) begin
                miscompares++;
                $display("FAIL right_valid cyc %0d: got %b expected %b", cyc, o_move_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (o_move_dir !== 2'd3) begin
                    miscompares++;
                    $display("FAIL right_dir cyc %0d: got %0d expected 3", cyc, o_move_dir);
                end
            end
            vectors++;
            if (o_dir_held !== exp_h) begin
                miscompares++;
                $display("FAIL right_held cyc %0d: got %b expected %b", cyc, o_dir_held, exp_h);
            end
            if (cyc == 19) i_right = 0;
        end
    endtask

    task automatic test_void_axis();
        logic       exp_v;
        logic [1:0] exp_d;
        do_reset();
        while (cyc < 9) tick();
        i_up = 1; i_down = 1; i_left = 1;
        repeat (13) begin
            tick();
            exp_v = (cyc == 11 || cyc == 15 || cyc == 17 || cyc == 21);
            exp_d = (cyc < 17) ? 2'd2 : 2'd0;
            vectors++;
            if (o_move_valid !== exp_v) begin
                miscompares++;
                $display("FAIL void_valid cyc %0d: got %b expected %b", cyc, o_move_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (o_move_dir !== exp_d) begin
                    miscompares++;
                    $display("FAIL void_dir cyc %0d: got %0d expected %0d", cyc, o_move_dir, exp_d);
                end
            end
            if (cyc == 15) i_down = 0;
        end
    endtask

    task automatic test_backpressure();
        logic exp_v;
        do_reset();
        i_move_ready = 0;
        while (cyc < 9) tick();
        i_left = 1;
        repeat (10) begin
            tick();
            exp_v = (cyc >= 11 && cyc <= 17) || cyc == 19;
            vectors++;
            if (o_move_valid !== exp_v) begin
                miscompares++;
                $display("FAIL bp_valid cyc %0d: got %b expected %b", cyc, o_move_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (o_move_dir !== 2'd2) begin
                    miscompares++;
                    $display("FAIL bp_dir cyc %0d: got %0d expected 2", cyc, o_move_dir);
                end
            end
            if (cyc == 16) i_move_ready = 1;
        end
    endtask

    task automatic test_fire_cooldown();
        logic exp_f;
        int   nxt;
        do_reset();
        repeat (10) begin
            nxt = cyc + 1;
            i_fire_n = !(nxt == 5 || nxt == 6 || nxt == 8 || nxt == 9);
            tick();
            exp_f = (cyc == 6 || cyc == 9);
            vectors++;
            if (o_fire_valid !== exp_f) begin
                miscompares++;
                $display("FAIL fire_valid cyc %0d: got %b expected %b", cyc, o_fire_valid, exp_f);
            end
        end
        i_fire_n = 1;
    endtask

    task automatic test_fire_hold();
        logic exp_f;
        do_reset();
        i_fire_ready = 0;
        i_fire_n = 0;
        repeat (6) begin
            tick();
            i_fire_n = !(cyc == 3);
            exp_f = (cyc >= 2 && cyc <= 5);
            vectors++;
            if (o_fire_valid !== exp_f) begin
                miscompares++;
                $display("FAIL fire_hold cyc %0d: got %b expected %b", cyc, o_fire_valid, exp_f);
            end
            if (cyc == 5) i_fire_ready = 1;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic exp_v, exp_h;
        do_reset();
        i_down = 1;
        while (cyc < 13) begin
            tick();
            i_fire_n = !(cyc == 11);
            exp_v = (cyc == 2 || cyc == 6 || cyc == 8 || cyc == 10 || cyc == 12);
            vectors++;
            if (o_move_valid !== exp_v) begin
                miscompares++;
                $display("FAIL pre_rst_valid cyc %0d: got %b expected %b", cyc, o_move_valid, exp_v);
            end
        end
        vectors++;
        if ({o_fire_valid, o_dir_held, o_move_dir} !== 4'b1101) begin
            miscompares++;
            $display("FAIL pre_rst_state: got %b expected 1101",
                     {o_fire_valid, o_dir_held, o_move_dir});
        end
        rst_n = 0;
        #1;
        vectors++;
        if ({o_move_valid, o_move_dir, o_fire_valid, o_dir_held} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_clear: got %b expected 00000",
                     {o_move_valid, o_move_dir, o_fire_valid, o_dir_held});
        end
        tick();
        vectors++;
        if ({o_move_valid, o_move_dir, o_fire_valid, o_dir_held} !== 5'b0) begin
            miscompares++;
            $display("FAIL held_in_reset: got %b expected 00000",
                     {o_move_valid, o_move_dir, o_fire_valid, o_dir_held});
        end
        rst_n = 1;
        repeat (7) begin
            tick();
            exp_v = (cyc == 16 || cyc == 20);
            exp_h = (cyc >= 16);
            vectors++;
            if (o_move_valid !== exp_v || (exp_v && o_move_dir !== 2'd1)) begin
                miscompares++;
                $display("FAIL post_rst_step cyc %0d: got %b/%0d expected %b/1", cyc,
                         o_move_valid, o_move_dir, exp_v);
            end
            vectors++;
            if (o_dir_held !== exp_h) begin
                miscompares++;
                $display("FAIL post_rst_held cyc %0d: got %b expected %b", cyc, o_dir_held, exp_h);
            end
        end
        i_down = 0;
    endtask

    initial begin
        test_reset();
        test_hold_right();
        test_void_axis();
        test_backpressure();
        test_fire_cooldown();
        test_fire_hold();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
